// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 request driver: command/response codes,
// driver FSM encoding and the queued request record.
package calc1_pkg;

  typedef enum logic [3:0] {
    CMD_NONE = 4'd0,
    CMD_ADD  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_SHL  = 4'd5,
    CMD_SHR  = 4'd6
  } calc1_cmd_e;

  typedef enum logic [1:0] {
    RSP_NONE    = 2'd0,
    RSP_OK      = 2'd1,
    RSP_ERROR   = 2'd2,
    RSP_TIMEOUT = 2'd3
  } calc1_rsp_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_DATA = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } drv_state_e;

  typedef struct packed {
    logic [0:3]  cmd;
    logic [0:31] op1;
    logic [0:31] op2;
    logic [0:1]  tag;
  } req_entry_t;

  // A zero command carries no work and is dropped before queueing.
  function automatic logic is_nop_cmd(input logic [0:3] cmd);
    return cmd == CMD_NONE;
  endfunction

endpackage

// File: rtl/calc1_req_fifo.sv
// Request queue for the calc1 driver; pointers carry one extra wrap bit so
// full and empty are distinguishable without an occupancy counter.
module calc1_req_fifo
  import calc1_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       c_clk,
  input  logic       reset,
  input  logic       push,
  input  req_entry_t din,
  input  logic       pop,
  output req_entry_t dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  req_entry_t  mem [DEPTH];

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge c_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/calc1_req_driver.sv
// Drives one calc1 request port from a host-side queue: issues cmd/op1 then
// op2, waits for the response (or a local timeout) and reports completion.
module calc1_req_driver
  import calc1_pkg::*;
#(
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [0:3]  host_cmd,
  input  logic [0:31] host_op1,
  input  logic [0:31] host_op2,
  input  logic [0:1]  host_tag,
  output logic [0:3]  req_cmd_out,
  output logic [0:31] req_data_out,
  input  logic [0:1]  out_resp_in,
  input  logic [0:31] out_data_in,
  output logic        rsp_valid,
  output logic [0:1]  rsp_resp,
  output logic [0:31] rsp_data,
  output logic [0:1]  rsp_tag,
  output logic        rsp_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  drv_state_e  state, state_n;
  req_entry_t  cur;
  req_entry_t  fifo_dout;
  req_entry_t  fifo_din;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] cnt;
  logic [0:1]  cap_resp;
  logic [0:31] cap_data;
  logic        cap_to;
  logic        wait_hit, wait_expire;

  assign host_ready = !fifo_full;
  assign fifo_push  = host_valid && !fifo_full && !is_nop_cmd(host_cmd);
  assign fifo_din   = '{cmd: host_cmd, op1: host_op1, op2: host_op2, tag: host_tag};

  calc1_req_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .c_clk (c_clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wait_hit    = (out_resp_in != '0);
  assign wait_expire = (cnt == CNT_LAST);

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cur      <= '0;
      cnt      <= '0;
      cap_resp <= '0;
      cap_data <= '0;
      cap_to   <= 1'b0;
    end else begin
      state <= state_n;
      if (fifo_pop) cur <= fifo_dout;
      if (state == ST_WAIT) begin
        // A response arriving on the last allowed cycle still wins over timeout.
        if (wait_hit) begin
          cap_resp <= out_resp_in;
          cap_data <= out_data_in;
          cap_to   <= 1'b0;
          cnt      <= '0;
        end else if (wait_expire) begin
          cap_resp <= RSP_TIMEOUT;
          cap_data <= '0;
          cap_to   <= 1'b1;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  always_comb begin
    state_n      = state;
    fifo_pop     = 1'b0;
    req_cmd_out  = '0;
    req_data_out = '0;
    rsp_valid    = 1'b0;
    rsp_resp     = '0;
    rsp_data     = '0;
    rsp_tag      = '0;
    rsp_timeout  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_n  = ST_CMD;
        end
      end
      ST_CMD: begin
        req_cmd_out  = cur.cmd;
        req_data_out = cur.op1;
        state_n      = ST_DATA;
      end
      ST_DATA: begin
        req_data_out = cur.op2;
        state_n      = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_hit || wait_expire) state_n = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid   = 1'b1;
        rsp_resp    = cap_resp;
        rsp_data    = cap_data;
        rsp_tag     = cur.tag;
        rsp_timeout = cap_to;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_n  = ST_CMD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_calc1_req_driver.sv
// Directed bench for calc1_req_driver with a small behavioural calc1 responder.
module tb_calc1_req_driver;

  logic        c_clk;
  logic        reset;
  logic        host_valid;
  logic        host_ready;
  logic [0:3]  host_cmd;
  logic [0:31] host_op1;
  logic [0:31] host_op2;
  logic [0:1]  host_tag;
  logic [0:3]  req_cmd_out;
  logic [0:31] req_data_out;
  logic [0:1]  out_resp_in;
  logic [0:31] out_data_in;
  logic        rsp_valid;
  logic [0:1]  rsp_resp;
  logic [0:31] rsp_data;
  logic [0:1]  rsp_tag;
  logic        rsp_timeout;

  int passed = 0;
  int total  = 0;

  calc1_req_driver #(
    .QDEPTH  (4),
    .TIMEOUT (31)
  ) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .host_cmd     (host_cmd),
    .host_op1     (host_op1),
    .host_op2     (host_op2),
    .host_tag     (host_tag),
    .req_cmd_out  (req_cmd_out),
    .req_data_out (req_data_out),
    .out_resp_in  (out_resp_in),
    .out_data_in  (out_data_in),
    .rsp_valid    (rsp_valid),
    .rsp_resp     (rsp_resp),
    .rsp_data     (rsp_data),
    .rsp_tag      (rsp_tag),
    .rsp_timeout  (rsp_timeout)
  );

  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // calc1 responder: add/sub report overflow/underflow as error, unknown codes error.
  function automatic logic [33:0] calc1(input logic [0:3] c, input logic [0:31] a, input logic [0:31] b);
    logic [32:0] s;
    case (c)
      4'd1: begin
        s = {1'b0, a} + {1'b0, b};
        calc1 = s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
      end
      4'd2:    calc1 = (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
      4'd5:    calc1 = {2'd1, a << b[27:31]};
      4'd6:    calc1 = {2'd1, a >> b[27:31]};
      default: calc1 = {2'd2, 32'd0};
    endcase
  endfunction

  int          model_lat = 0;
  logic        model_silent = 1'b0;
  int          m_phase;
  int          m_dly;
  logic [0:3]  m_cmd;
  logic [0:31] m_op1;
  logic [33:0] m_res;

  always @(negedge c_clk or negedge reset) begin
    if (!reset) begin
      m_phase     <= 0;
      m_dly       <= 0;
      out_resp_in <= '0;
      out_data_in <= '0;
    end else begin
      case (m_phase)
        0: if (req_cmd_out != '0) begin
             m_cmd   <= req_cmd_out;
             m_op1   <= req_data_out;
             m_phase <= 1;
           end
        1: begin
             m_res   <= calc1(m_cmd, m_op1, req_data_out);
             m_dly   <= model_lat;
             m_phase <= model_silent ? 0 : 2;
           end
        2: if (m_dly == 0) begin
             out_resp_in <= m_res[33:32];
             out_data_in <= m_res[31:0];
             m_phase     <= 3;
           end else begin
             m_dly <= m_dly - 1;
           end
        default: begin
             out_resp_in <= '0;
             out_data_in <= '0;
             m_phase     <= 0;
           end
      endcase
    end
  end

  logic [36:0] rsp_q[$];
  int          rsp_cnt = 0;
  int          issue_cnt = 0;

  always @(negedge c_clk) begin
    if (rsp_valid) begin
      rsp_q.push_back({rsp_resp, rsp_data, rsp_tag, rsp_timeout});
      rsp_cnt <= rsp_cnt + 1;
    end
    if (req_cmd_out != '0) issue_cnt <= issue_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [0:3] c, input logic [0:31] a, input logic [0:31] b, input logic [0:1] t);
    int n;
    host_cmd   = c;
    host_op1   = a;
    host_op2   = b;
    host_tag   = t;
    host_valid = 1'b1;
    n = 0;
    while (!host_ready && n < 200) begin
      @(negedge c_clk);
      n++;
    end
    chk("push_accept", host_ready, 1);
    @(negedge c_clk);
    host_valid = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic [0:1] er, input logic [0:31] ed,
                           input logic [0:1] et, input logic eto);
    int n;
    logic [36:0] r;
    n = 0;
    while (rsp_q.size() == 0 && n < 200) begin
      @(negedge c_clk);
      n++;
    end
    chk({tag, "_present"}, (rsp_q.size() != 0), 1);
    if (rsp_q.size() != 0) begin
      r = rsp_q.pop_front();
      chk({tag, "_resp"},    r[36:35], er);
      chk({tag, "_data"},    r[34:3],  ed);
      chk({tag, "_tag"},     r[2:1],   et);
      chk({tag, "_timeout"}, r[0],     eto);
    end
  endtask

  task automatic run_one(input string tag, input logic [0:3] c, input logic [0:31] a, input logic [0:31] b,
                         input logic [0:1] t, input logic [0:1] er, input logic [0:31] ed,
                         input logic eto, output int wc);
    int n;
    push(c, a, b, t);
    n = 0;
    while (req_cmd_out == '0 && n < 50) begin
      @(negedge c_clk);
      n++;
    end
    chk({tag, "_issue_latency"}, n, 1);
    chk({tag, "_cmd_phase_cmd"}, req_cmd_out, c);
    chk({tag, "_cmd_phase_data"}, req_data_out, a);
    @(negedge c_clk);
    chk({tag, "_data_phase_cmd"}, req_cmd_out, 0);
    chk({tag, "_data_phase_data"}, req_data_out, b);
    @(negedge c_clk);
    chk({tag, "_wait_cmd"}, req_cmd_out, 0);
    chk({tag, "_wait_data"}, req_data_out, 0);
    wc = 1;
    while (!rsp_valid && wc < 100) begin
      @(negedge c_clk);
      wc++;
    end
    chk({tag, "_rsp_seen"}, rsp_valid, 1);
    check_rsp(tag, er, ed, t, eto);
  endtask

  initial begin
    int wc;
    int r0, i0;
    host_valid = 1'b0;
    host_cmd   = '0;
    host_op1   = '0;
    host_op2   = '0;
    host_tag   = '0;
    reset      = 1'b0;

    repeat (3) @(negedge c_clk);
    chk("rst_host_ready",  host_ready, 1);
    chk("rst_req_cmd",     req_cmd_out, 0);
    chk("rst_req_data",    req_data_out, 0);
    chk("rst_rsp_valid",   rsp_valid, 0);
    chk("rst_rsp_resp",    rsp_resp, 0);
    chk("rst_rsp_data",    rsp_data, 0);
    chk("rst_rsp_tag",     rsp_tag, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    reset = 1'b1;
    @(negedge c_clk);

    run_one("add_ok", 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 2'd1, 32'h2000_0000, 1'b0, wc);
    run_one("add_ovf", 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 2'd2, 32'h0, 1'b0, wc);
    run_one("cmd3", 4'd3, 32'h0000_0011, 32'h0000_0022, 2'd3, 2'd2, 32'h0, 1'b0, wc);
    run_one("cmd4", 4'd4, 32'h0000_0033, 32'h0000_0044, 2'd0, 2'd2, 32'h0, 1'b0, wc);

    r0 = rsp_cnt;
    i0 = issue_cnt;
    push(4'd0, 32'h1234_5678, 32'h9ABC_DEF0, 2'd1);
    repeat (10) @(negedge c_clk);
    chk("nop_no_issue", issue_cnt, i0);
    chk("nop_no_rsp",   rsp_cnt, r0);

    model_lat = 2;
    push(4'd1, 32'd10,   32'd20, 2'd1);
    push(4'd2, 32'd50,   32'd8,  2'd2);
    push(4'd5, 32'd1,    32'd4,  2'd3);
    push(4'd6, 32'h80,   32'd3,  2'd0);
    push(4'd1, 32'd5,    32'd6,  2'd1);
    chk("b2b_full_not_ready", host_ready, 0);
    check_rsp("b2b0", 2'd1, 32'd30,   2'd1, 1'b0);
    check_rsp("b2b1", 2'd1, 32'd42,   2'd2, 1'b0);
    check_rsp("b2b2", 2'd1, 32'd16,   2'd3, 1'b0);
    check_rsp("b2b3", 2'd1, 32'h10,   2'd0, 1'b0);
    check_rsp("b2b4", 2'd1, 32'd11,   2'd1, 1'b0);
    repeat (4) @(negedge c_clk);
    chk("b2b_ready_again", host_ready, 1);

    model_lat    = 0;
    model_silent = 1'b1;
    run_one("tmo", 4'd2, 32'd9, 32'd4, 2'd2, 2'd3, 32'h0, 1'b1, wc);
    chk("tmo_wait_cycles", wc - 1, 31);
    model_silent = 1'b0;

    model_lat = 20;
    push(4'd1, 32'd1, 32'd1, 2'd1);
    push(4'd1, 32'd2, 32'd2, 2'd2);
    push(4'd1, 32'd3, 32'd3, 2'd3);
    repeat (3) @(negedge c_clk);
    chk("pre_rst_in_wait_cmd", req_cmd_out, 0);
    r0 = rsp_cnt;
    i0 = issue_cnt;
    reset = 1'b0;
    #1;
    chk("mid_rst_host_ready",  host_ready, 1);
    chk("mid_rst_req_cmd",     req_cmd_out, 0);
    chk("mid_rst_req_data",    req_data_out, 0);
    chk("mid_rst_rsp_valid",   rsp_valid, 0);
    chk("mid_rst_rsp_resp",    rsp_resp, 0);
    chk("mid_rst_rsp_data",    rsp_data, 0);
    chk("mid_rst_rsp_tag",     rsp_tag, 0);
    chk("mid_rst_rsp_timeout", rsp_timeout, 0);
    @(negedge c_clk);
    reset = 1'b1;
    repeat (40) @(negedge c_clk);
    chk("post_rst_no_rsp",   rsp_cnt, r0);
    chk("post_rst_no_issue", issue_cnt, i0);
    chk("post_rst_ready",    host_ready, 1);
    chk("post_rst_q_empty",  rsp_q.size(), 0);

    model_lat = 0;
    run_one("post_rst_shl", 4'd5, 32'h0000_0003, 32'd8, 2'd2, 2'd1, 32'h0000_0300, 1'b0, wc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/calc1_req_driver.md
CALC1_REQ_DRIVER -- requirements
Module: calc1_req_driver

Interface
REQ-001 SHALL have parameter QDEPTH, default 4: request queue depth in entries, power of two.
REQ-002 SHALL have parameter TIMEOUT, default 31: maximum WAIT cycles before a local timeout.
REQ-003 SHALL have port c_clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port host_valid, input, 1 bit: host request present.
REQ-006 SHALL have port host_ready, output, 1 bit: queue can accept a request.
REQ-007 SHALL have port host_cmd, input, [0:3]: operation code; 1 add, 2 sub, 5 shl, 6 shr, any other code is forwarded unchanged.
REQ-008 SHALL have ports host_op1 and host_op2, input, [0:31] each: first and second operand.
REQ-009 SHALL have port host_tag, input, [0:1]: opaque id, returned with the response.
REQ-010 SHALL have port req_cmd_out, output, [0:3]: drives calc1 reqN_cmd_in.
REQ-011 SHALL have port req_data_out, output, [0:31]: drives calc1 reqN_data_in.
REQ-012 SHALL have port out_resp_in, input, [0:1]: calc1 out_respN.
REQ-013 SHALL have port out_data_in, input, [0:31]: calc1 out_dataN.
REQ-014 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have ports rsp_resp [0:1], rsp_data [0:31] and rsp_tag [0:1], outputs: completion content, valid only while rsp_valid=1.
REQ-016 SHALL have port rsp_timeout, output, 1 bit: set with rsp_valid when the request timed out.

Function
REQ-017 SHALL push {cmd, op1, op2, tag} into a FIFO when host_valid=1 and host_ready=1; host_ready=0 when the FIFO holds QDEPTH entries.
REQ-018 SHALL discard host_cmd=0 requests at push: no FIFO entry, no response.
REQ-019 SHALL sequence the FSM IDLE -> CMD -> DATA -> WAIT -> DONE -> IDLE.
REQ-020 IDLE: SHALL go to CMD on the cycle after the FIFO becomes non-empty, popping the head entry.
REQ-021 CMD (1 cycle): SHALL drive req_cmd_out=cmd and req_data_out=op1.
REQ-022 DATA (1 cycle): SHALL drive req_cmd_out=0 and req_data_out=op2.
REQ-023 WAIT and IDLE: SHALL drive req_cmd_out=0 and req_data_out=0.
REQ-024 WAIT: SHALL capture out_resp_in and out_data_in on the first cycle out_resp_in!=0 and go to DONE.
REQ-025 WAIT: SHALL count cycles; on reaching TIMEOUT with out_resp_in=0, SHALL go to DONE with rsp_resp=3, rsp_data=0, rsp_timeout=1.
REQ-026 DONE (1 cycle): SHALL assert rsp_valid with the captured resp/data and the entry's tag; next state IDLE, or CMD directly if the FIFO is non-empty.
REQ-027 SHALL allow only one request outstanding on the calc1 port at a time.
REQ-028 SHALL complete a push and the FSM pop in the same cycle with correct occupancy; a push into an empty FIFO while the FSM is in IDLE is issued on the following cycle.
REQ-029 SHALL wrap FIFO pointers modulo QDEPTH and keep one extra bit to distinguish full from empty.
REQ-030 SHALL ignore out_resp_in outside WAIT.

Reset
REQ-031 While reset=0: SHALL force FSM=IDLE, FIFO empty, timeout counter=0, host_ready=1, req_cmd_out=0, req_data_out=0, rsp_valid=0, rsp_resp=0, rsp_data=0, rsp_tag=0, rsp_timeout=0.
REQ-032 SHALL drop any in-flight request on reset assertion mid-operation, without a response.

Structure
REQ-033 SHALL define the command codes (0,1,2,5,6), the response codes (0 none, 1 ok, 2 error, 3 local timeout) and the FSM state encoding in shared package calc1_pkg.
REQ-034 SHALL implement the FIFO as sub-module calc1_req_fifo; the FSM and the timeout counter sit in the top module.

Verification
REQ-035 Stimulus: add, op1=0x00000001, op2=0x1FFFFFFF, tag=1. Required: req_cmd_out=1 for one cycle followed by op2 for one cycle, then rsp_resp=1, rsp_data=0x20000000, rsp_tag=1.
REQ-036 Stimulus: add, op1=0xFFFFFFFF, op2=0x00000001. Required: rsp_resp=2, rsp_timeout=0.
REQ-037 Stimulus: cmd=3, then cmd=4. Required: both forwarded unchanged, each gets rsp_resp=2.
REQ-038 Stimulus: 5 back-to-back requests with QDEPTH=4 while the FSM is busy. Required: host_ready=0 while 4 entries are queued; all 5 responses return in order with tags preserved.
REQ-039 Stimulus: calc1 model holds out_resp_in=0. Required: exactly TIMEOUT=31 WAIT cycles, then rsp_resp=3, rsp_timeout=1.
REQ-040 Stimulus: reset asserted in WAIT with 2 entries queued. Required: outputs take their reset values immediately; no rsp_valid; FIFO empty after release.
